// File: rtl/pll_dda_seq.sv
// PLL dynamic-delay-adjust sequencer: applies a signed delay step, holds for settling, then waits for lock.
// Define PLL_DDA_TIMEOUT_EN to bound the lock wait by LOCK_TIMEOUT cycles (ACK with ERR on expiry).
module pll_dda_seq #(
   parameter int SETTLE_CYC   = 4,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  logic       CLKINB_DEL,
   input  logic       RSTB,
   input  logic       REQ,
   input  logic [4:0] REQ_STEP,
   input  logic       PLL_LOCK,
   output logic       ACK,
   output logic       ERR,
   output logic       BUSY,
   output logic [4:0] CUR_STEP,
   output logic       DDAMODE,
   output logic       DDAIZR,
   output logic       DDAILAG,
   output logic [2:0] DDAIDEL
);

   // One counter serves the settle hold and, when enabled, the lock timeout.
   localparam int CNT_MAX = (LOCK_TIMEOUT > SETTLE_CYC) ? LOCK_TIMEOUT : SETTLE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
`ifdef PLL_DDA_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
`endif

   typedef enum logic [1:0] {IDLE, SETTLE, WAIT_LOCK} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             lock_meta_reg, lock_sync_reg;
   logic             ack_reg, ack_next;
   logic             err_reg, err_next;
   logic             busy_reg, busy_next;
   logic [4:0]       cur_step_reg, cur_step_next;
   logic             ddamode_reg, ddamode_next;
   logic             ddaizr_reg, ddaizr_next;
   logic             ddailag_reg, ddailag_next;
   logic [2:0]       ddaidel_reg, ddaidel_next;
   logic [4:0]       step_mag;
   logic             step_legal;

   always_ff @(posedge CLKINB_DEL or posedge RSTB) begin
      if (RSTB) begin
         lock_meta_reg <= 1'b0;
         lock_sync_reg <= 1'b0;
      end else begin
         lock_meta_reg <= PLL_LOCK;
         lock_sync_reg <= lock_meta_reg;
      end
   end

   // Magnitude of the two's complement request; -16 maps to 16 and is rejected.
   always_comb begin
      step_mag   = REQ_STEP[4] ? (5'd0 - REQ_STEP) : REQ_STEP;
      step_legal = (step_mag <= 5'd8);
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      ack_next      = 1'b0;
      err_next      = 1'b0;
      busy_next     = busy_reg;
      cur_step_next = cur_step_reg;
      ddamode_next  = ddamode_reg;
      ddaizr_next   = ddaizr_reg;
      ddailag_next  = ddailag_reg;
      ddaidel_next  = ddaidel_reg;
      case (state_reg)
         IDLE: begin
            // The ACK cycle itself never samples REQ, so ACK stays one cycle wide.
            if (REQ && !ack_reg) begin
               if (!step_legal) begin
                  ack_next = 1'b1;
                  err_next = 1'b1;
               end else if (REQ_STEP == cur_step_reg) begin
                  ack_next = 1'b1;
               end else begin
                  cur_step_next = REQ_STEP;
                  ddamode_next  = 1'b1;
                  ddaizr_next   = (step_mag == 5'd0);
                  ddailag_next  = REQ_STEP[4];
                  ddaidel_next  = (step_mag == 5'd0) ? 3'd0 : (step_mag[2:0] - 3'd1);
                  busy_next     = 1'b1;
                  cnt_next      = '0;
                  state_next    = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (cnt_reg == SETTLE_LAST) begin
               cnt_next   = '0;
               state_next = WAIT_LOCK;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         WAIT_LOCK: begin
            if (lock_sync_reg) begin
               ack_next   = 1'b1;
               busy_next  = 1'b0;
               state_next = IDLE;
            end
`ifdef PLL_DDA_TIMEOUT_EN
            else if (cnt_reg == TIMEOUT_LAST) begin
               ack_next   = 1'b1;
               err_next   = 1'b1;
               busy_next  = 1'b0;
               cnt_next   = '0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
`endif
         end
         default: begin
            busy_next  = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLKINB_DEL or posedge RSTB) begin
      if (RSTB) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         ack_reg      <= 1'b0;
         err_reg      <= 1'b0;
         busy_reg     <= 1'b0;
         cur_step_reg <= 5'd0;
         ddamode_reg  <= 1'b0;
         ddaizr_reg   <= 1'b1;
         ddailag_reg  <= 1'b0;
         ddaidel_reg  <= 3'd0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         ack_reg      <= ack_next;
         err_reg      <= err_next;
         busy_reg     <= busy_next;
         cur_step_reg <= cur_step_next;
         ddamode_reg  <= ddamode_next;
         ddaizr_reg   <= ddaizr_next;
         ddailag_reg  <= ddailag_next;
         ddaidel_reg  <= ddaidel_next;
      end
   end

   assign ACK      = ack_reg;
   assign ERR      = err_reg;
   assign BUSY     = busy_reg;
   assign CUR_STEP = cur_step_reg;
   assign DDAMODE  = ddamode_reg;
   assign DDAIZR   = ddaizr_reg;
   assign DDAILAG  = ddailag_reg;
   assign DDAIDEL  = ddaidel_reg;

endmodule

// File: doc/pll_dda_seq.md
PLL_DDA_SEQ -- requirements
Module: pll_dda_seq

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 4, giving the cycles held after a code change before lock is sampled (legal range 1..255).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 1024, giving the maximum cycles spent in WAIT_LOCK (legal range 1..65535).
REQ-003 The block SHALL have port CLKINB_DEL  in  1  clock, the PLL reference clock.
REQ-004 The block SHALL have port RSTB  in  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port REQ  in  1  delay-change request, level-sensitive.
REQ-006 The block SHALL have port REQ_STEP  in  5  requested delay step, two's complement.
REQ-007 The block SHALL have port PLL_LOCK  in  1  PLL LOCK output, asynchronous to CLKINB_DEL.
REQ-008 The block SHALL have port ACK  out  1  one-cycle completion pulse.
REQ-009 The block SHALL have port ERR  out  1  error qualifier, valid only while ACK=1.
REQ-010 The block SHALL have port BUSY  out  1  sequence in progress.
REQ-011 The block SHALL have port CUR_STEP  out  5  currently applied step, two's complement.
REQ-012 The block SHALL have ports DDAMODE, DDAIZR, DDAILAG  out  1 each  PLL dynamic-delay controls.
REQ-013 The block SHALL have port DDAIDEL  out  3  PLL delay magnitude code.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, WAIT_LOCK; all outputs SHALL be registered.
REQ-015 PLL_LOCK SHALL pass through a 2-flop synchronizer; all lock decisions SHALL use the synchronized value.
REQ-016 REQ SHALL be sampled only in IDLE; REQ in SETTLE/WAIT_LOCK SHALL be ignored.
REQ-017 Step encoding: 0 -> DDAIZR=1, DDAILAG=0, DDAIDEL=000; +n (1..8) -> DDAIZR=0, DDAILAG=0, DDAIDEL=n-1; -n (1..8) -> DDAIZR=0, DDAILAG=1, DDAIDEL=n-1.
REQ-018 REQ_STEP outside -8..+8 SHALL produce ACK=1, ERR=1 in cycle N+1 (N = sample cycle), with no change to DDA outputs, CUR_STEP or BUSY.
REQ-019 A legal REQ_STEP equal to CUR_STEP SHALL produce ACK=1, ERR=0 in N+1, with BUSY staying 0 and no output change.
REQ-020 A legal, differing REQ_STEP SHALL, in N+1, update DDAIZR/DDAILAG/DDAIDEL/CUR_STEP, set DDAMODE=1, set BUSY=1, and enter SETTLE.
REQ-021 SETTLE SHALL last exactly SETTLE_CYC cycles, ignoring lock, then enter WAIT_LOCK.
REQ-022 WAIT_LOCK SHALL exit on the first cycle the synchronized lock is 1; the next cycle SHALL give ACK=1, ERR=0, BUSY=0, state IDLE.
REQ-023 DDAMODE, once set, SHALL stay 1 until reset.
REQ-024 ACK SHALL always be exactly one cycle; REQ still high in the cycle after ACK SHALL be taken as a new request.

Reset
REQ-025 RSTB=1 SHALL asynchronously force IDLE, ACK=0, ERR=0, BUSY=0, CUR_STEP=0, DDAMODE=0, DDAIZR=1, DDAILAG=0, DDAIDEL=000, timeout counter=0, and clear both synchronizer flops.
REQ-026 Reset during SETTLE or WAIT_LOCK SHALL abandon the sequence with no ACK issued.

Configuration
REQ-027 With macro PLL_DDA_TIMEOUT_EN defined, WAIT_LOCK SHALL count cycles; after LOCK_TIMEOUT cycles without lock, the next cycle SHALL give ACK=1, ERR=1, BUSY=0, state IDLE, with the new code and CUR_STEP retained.
REQ-028 Without PLL_DDA_TIMEOUT_EN, no counter SHALL be built and WAIT_LOCK SHALL wait indefinitely.

Verification
REQ-029 Reset release then REQ, REQ_STEP=+3 at N -> N+1: DDAMODE=1, DDAIZR=0, DDAILAG=0, DDAIDEL=010, CUR_STEP=+3, BUSY=1; ACK one cycle after synchronized lock returns.
REQ-030 REQ_STEP=-8 -> DDAILAG=1, DDAIDEL=111; then REQ_STEP=0 -> DDAIZR=1, DDAIDEL=000, CUR_STEP=0.
REQ-031 REQ_STEP=+9 (01001), then -9 (10111) -> each: ACK=1, ERR=1 at N+1, outputs unchanged, BUSY=0.
REQ-032 REQ_STEP equal to CUR_STEP (+3 after +3) -> ACK=1, ERR=0 at N+1, BUSY never asserted.
REQ-033 PLL_DDA_TIMEOUT_EN, LOCK_TIMEOUT=16, PLL_LOCK held 0 -> ACK=1, ERR=1 after SETTLE_CYC+16 WAIT cycles, CUR_STEP keeps new value; without macro, BUSY stays 1 for at least 1000 cycles.
REQ-034 RSTB pulsed during WAIT_LOCK -> immediate reset values per REQ-025, no ACK; REQ held through BUSY -> ignored until IDLE.
